alu_cmd_queue: RTL and testbench

Command buffer and issue stage that sits directly upstream of the ALU function decoder. Producers push 4-bit ALU commands with their signed operands over a valid/ready handshake. The block stores them in a small FIFO and issues them in order, one per cycle, through a registered issue stage. It drives alu_func_decoder, which selects the arith/logic/cmp/shift unit, plus the unit sub-function and the operands. The ALU can stall issue.

---
 rtl/alu_cmd_queue_if.sv | 37 +++
 rtl/alu_cmd_queue.sv | 146 ++++++++++++++
 tb/tb_alu_cmd_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_queue_if.sv
// Command/issue bus for alu_cmd_queue.
//   slave  : the queue (takes in_*/out_stall, drives in_ready and all issue outputs)
//   master : producer + ALU side (drives in_*/out_stall, observes the rest)
// level is wide enough for DEPTH+1 (FIFO plus issue register).
interface alu_cmd_queue_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 2;

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_func;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_stall;
  logic [1:0]            alu_func_decoder;
  logic [1:0]            alu_func_sub;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [LVL_W-1:0]      level;
  logic [CNT_WIDTH-1:0]  issue_cnt;

  modport slave (
    input  in_valid, in_func, in_a, in_b, out_stall,
    output in_ready, out_valid, alu_func_decoder, alu_func_sub,
           out_a, out_b, level, issue_cnt
  );

  modport master (
    output in_valid, in_func, in_a, in_b, out_stall,
    input  in_ready, out_valid, alu_func_decoder, alu_func_sub,
           out_a, out_b, level, issue_cnt
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: in-order command FIFO plus registered issue stage feeding the
// ALU function decoder.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-low reset
//   bus  : alu_cmd_queue_if.slave -- valid/ready command input, stallable issue
//          outputs (unit select, sub-function, operands), level and issue_cnt.
// An empty issue register is loaded from the FIFO head first, otherwise
// directly from the accepted input (fall-through), so an idle queue has a
// single cycle of latency.
module alu_cmd_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  alu_cmd_queue_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LVL_W = PTR_W + 2;
  localparam int unsigned ENT_W = 4 + 2 * DATA_WIDTH;

  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic [ENT_W-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            dec_q, dec_d;
  logic [1:0]            sub_q, sub_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;

  logic             in_ready;
  logic             push, consume, load, fifo_empty, pop, fall, wr;
  logic [ENT_W-1:0] in_entry, head;

  always_comb begin
    // DEPTH is a power of two, so the count MSB is set exactly when full.
    in_ready   = RST & ~count_q[PTR_W];
    push       = bus.in_valid & in_ready;
    consume    = out_valid_q & ~bus.out_stall;
    load       = ~out_valid_q | consume;
    fifo_empty = (count_q == '0);
    pop        = load & ~fifo_empty;
    fall       = load & fifo_empty & push;
    wr         = push & ~fall;
    in_entry   = {bus.in_func, bus.in_a, bus.in_b};
    head       = mem_q[rd_ptr_q];

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    sub_d       = sub_q;
    a_d         = a_q;
    b_d         = b_q;
    level_d     = level_q;
    issue_cnt_d = issue_cnt_q;

    if (wr) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    if (load) begin
      if (pop) begin
        out_valid_d = 1'b1;
        dec_d       = head[ENT_W-1 -: 2];
        sub_d       = head[ENT_W-3 -: 2];
        a_d         = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
        b_d         = head[DATA_WIDTH-1:0];
      end else if (fall) begin
        out_valid_d = 1'b1;
        dec_d       = bus.in_func[3:2];
        sub_d       = bus.in_func[1:0];
        a_d         = bus.in_a;
        b_d         = bus.in_b;
      end else begin
        // Data outputs keep the last issued command while idle.
        out_valid_d = 1'b0;
      end
    end

    if (consume) begin
      issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
    end
    if (push && !consume) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push && consume) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      sub_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      level_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      sub_q       <= sub_d;
      a_q         <= a_d;
      b_q         <= b_d;
      level_q     <= level_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = out_valid_q;
  assign bus.alu_func_decoder = dec_q;
  assign bus.alu_func_sub     = sub_q;
  assign bus.out_a            = a_q;
  assign bus.out_b            = b_q;
  assign bus.level            = level_q;
  assign bus.issue_cnt        = issue_cnt_q;
endmodule

// File: tb/tb_alu_cmd_queue.sv
module tb_alu_cmd_queue;
  logic clk;
  logic rst_n;

  alu_cmd_queue_if #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) bus ();

  alu_cmd_queue #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; scoreboard entry is pushed when the
  // handshake will complete at the coming edge.
  task automatic cycle(input bit v, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input bit stall, output bit acc);
    bus.in_valid  = v;
    bus.in_func   = f;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_stall = stall;
    @(negedge clk);
    acc = v && bus.in_ready;
    if (acc) exp_q.push_back({f, a, b});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every consumed command against the scoreboard and
  // checks that outputs held steady across every stalled edge.
  logic        hold_v = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("stall_hold", {bus.out_valid, bus.alu_func_decoder, bus.alu_func_sub,
                             bus.out_a, bus.out_b}, held);
      if (bus.out_valid && !bus.out_stall) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_unexpected: got %0h expected none",
                   {bus.alu_func_decoder, bus.alu_func_sub, bus.out_a, bus.out_b});
        end else begin
          check("issue_order", {bus.alu_func_decoder, bus.alu_func_sub, bus.out_a, bus.out_b},
                exp_q.pop_front());
        end
      end
      hold_v = bus.out_valid && bus.out_stall;
      held   = {bus.out_valid, bus.alu_func_decoder, bus.alu_func_sub, bus.out_a, bus.out_b};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    int k;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_func = '0; bus.in_a = '0; bus.in_b = '0; bus.out_stall = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_level", bus.level, 0);
    check("rst_issue_cnt", bus.issue_cnt, 0);
    check("rst_out_ab", {bus.out_a, bus.out_b}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single command latency
    cycle(1, 4'b0110, 16'h8001, 16'h0003, 0, acc);
    check("t1_acc", acc, 1);
    check("t1_valid", bus.out_valid, 1);
    check("t1_dec", bus.alu_func_decoder, 2'b01);
    check("t1_sub", bus.alu_func_sub, 2'b10);
    check("t1_a", bus.out_a, 16'h8001);
    check("t1_b", bus.out_b, 16'h0003);
    check("t1_level", bus.level, 1);
    check("t1_cnt0", bus.issue_cnt, 0);
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t1_cnt1", bus.issue_cnt, 1);
    check("t1_idle_valid", bus.out_valid, 0);
    check("t1_idle_a", bus.out_a, 16'h8001);
    check("t1_level0", bus.level, 0);

    // Stall and fill: 6 offered, 5 accepted
    n_acc = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 4'(i + 8), 16'(16'h1000 + i), 16'(16'h2000 + i), 1, acc);
      if (acc) n_acc++;
      if (i == 5) begin
        check("t2_full_ready", bus.in_ready, 0);
        check("t2_level5", bus.level, 5);
        check("t2_frozen_a", bus.out_a, 16'h1001);
      end
    end
    check("t2_accepted", n_acc, 5);
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t2_ready_after_pop", bus.in_ready, 1);
    check("t2_level4", bus.level, 4);
    check("t2_second_a", bus.out_a, 16'h1002);
    for (int i = 0; i < 4; i++) cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t2_drained_level", bus.level, 0);
    check("t2_cnt", bus.issue_cnt, 6);

    // Continuous streaming
    for (int i = 0; i < 20; i++) begin
      cycle(1, 4'(i), 16'(i * 257), 16'(~i), 0, acc);
      check("t3_acc", acc, 1);
      check("t3_level", bus.level, 1);
    end
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t3_cnt", bus.issue_cnt, 26);
    check("t3_level0", bus.level, 0);

    // Async reset mid-stream at level 3
    for (int i = 0; i < 3; i++) cycle(1, 4'hF, 16'(16'h7770 + i), 16'hBEEF, 1, acc);
    check("t4_level3", bus.level, 3);
    #3 rst_n = 1'b0;
    #1;
    check("t4_rst_valid", bus.out_valid, 0);
    check("t4_rst_func", {bus.alu_func_decoder, bus.alu_func_sub}, 0);
    check("t4_rst_ab", {bus.out_a, bus.out_b}, 0);
    check("t4_rst_level", bus.level, 0);
    check("t4_rst_cnt", bus.issue_cnt, 0);
    check("t4_rst_ready", bus.in_ready, 0);
    exp_q.delete();
    bus.in_valid = 1'b0; bus.out_stall = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1, 4'b1101, 16'h1234, 16'h5678, 0, acc);
    check("t4_fresh_valid", bus.out_valid, 1);
    check("t4_fresh_func", {bus.alu_func_decoder, bus.alu_func_sub}, 4'b1101);
    check("t4_fresh_ab", {bus.out_a, bus.out_b}, 32'h1234_5678);
    check("t4_fresh_level", bus.level, 1);
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t4_cnt1", bus.issue_cnt, 1);

    // issue_cnt wrap: 255 more makes 256 consumed since reset
    for (int i = 0; i < 255; i++) cycle(1, 4'(i), 16'(i), 16'(i + 1), 0, acc);
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t5_wrap0", bus.issue_cnt, 0);
    cycle(1, 4'h3, 16'hFFFF, 16'h8000, 0, acc);
    cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
    check("t5_wrap1", bus.issue_cnt, 1);

    // Toggling stall with random valid
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom), i[0], acc);
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      cycle(0, 4'h0, 16'h0, 16'h0, 0, acc);
      k++;
    end
    check("t6_drained", exp_q.size(), 0);
    check("t6_level0", bus.level, 0);
    check("t6_valid0", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
